// File: rtl/fetch_controller_pkg.sv
// Shared state encoding, buffer entry type and PC helpers for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_idx(input logic [31:0] byte_pc);
      return byte_pc >> 2;
   endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Memory read port and decode-side valid/ready handshake of the fetch controller.
interface fetch_controller_if;
   import fetch_pkg::*;

   logic [31:0]        mem_addr;
   logic [INSTR_W-1:0] mem_instr;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [31:0]        out_pc;

   modport master (
      output mem_addr,
      input  mem_instr,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  mem_addr,
      output mem_instr,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );

endinterface

// File: rtl/fetch_controller_skid_fifo.sv
// Two-entry skid FIFO holding {instr, pc} pairs between memory response and decode.
module fetch_skid_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_entry_t entries [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   // Write slot sits count entries past the read slot; when full it aliases the slot being popped.
   assign wr_ptr  = rd_ptr ^ count[0];
   assign do_pop  = pop & (count != 2'd0);
   assign do_push = push & ((count != FULL) | do_pop);
   assign head    = entries[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) entries[i] <= '0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         if (do_push) entries[wr_ptr] <= push_data;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one memory read per cycle, buffers responses for decode.
// Optional saturating performance counters are enabled with FETCH_PERF_CNT_EN.
//
//   state | meaning
//   IDLE  | waiting for start; redirects ignored
//   FETCH | issuing reads while the skid FIFO has room
//   HALT  | PC ran past the memory; no issue, FIFO drains
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int          MEM_DEPTH = 30,
   parameter logic [31:0] BOOT_PC   = 32'h0,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   fetch_controller_if.master  fetch_bus,
   output logic                busy,
   output logic                done
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_stall,
   output logic [15:0]         perf_flush
`endif
);

   localparam logic [31:0] DEPTH_WORDS = MEM_DEPTH;

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  mem_addr_q, mem_addr_nxt;
   logic [31:0]  issue_pc, issue_pc_nxt;
   logic         inflight, inflight_nxt;
   logic         issue;
   logic         deq;
   logic         redirect_take;
   logic         room;
   logic [1:0]   count;
   fetch_entry_t head;

   assign deq           = fetch_bus.out_valid & fetch_bus.out_ready;
   assign redirect_take = redirect_valid & (state != IDLE);
   assign room          = (({1'b0, count} + {2'b00, inflight} - {2'b00, deq}) < 3'd2);

   // The response arriving in a redirect cycle belongs to the old path and is dropped.
   fetch_skid_fifo #(.DEPTH(BUF_DEPTH)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight & ~redirect_take),
      .push_data ('{instr: fetch_bus.mem_instr, pc: issue_pc}),
      .pop       (deq),
      .flush     (redirect_take),
      .count     (count),
      .head      (head)
   );

   assign fetch_bus.mem_addr  = mem_addr_q;
   assign fetch_bus.out_valid = (count != 2'd0);
   assign fetch_bus.out_instr = head.instr;
   assign fetch_bus.out_pc    = head.pc;
   assign busy                = (state != IDLE);
   assign done                = (state == HALT) && (count == 2'd0) && !inflight;

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      mem_addr_nxt = mem_addr_q;
      issue_pc_nxt = issue_pc;
      inflight_nxt = 1'b0;
      issue        = 1'b0;
      if (redirect_take) begin
         pc_nxt    = redirect_pc & ~32'h3;
         state_nxt = (word_idx(redirect_pc) < DEPTH_WORDS) ? FETCH : HALT;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = FETCH;
                  pc_nxt    = BOOT_PC;
               end
            end
            FETCH: begin
               if (word_idx(pc) >= DEPTH_WORDS) begin
                  state_nxt = HALT;
               end else if (room) begin
                  issue        = 1'b1;
                  mem_addr_nxt = word_idx(pc);
                  pc_nxt       = pc + PC_STEP;
                  issue_pc_nxt = pc;
                  inflight_nxt = 1'b1;
               end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= BOOT_PC;
         mem_addr_q <= 32'd0;
         issue_pc   <= 32'd0;
         inflight   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         mem_addr_q <= mem_addr_nxt;
         issue_pc   <= issue_pc_nxt;
         inflight   <= inflight_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
         perf_flush   <= 16'd0;
      end else begin
         if (issue && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if ((state == FETCH) && !issue && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
         if (redirect_take && (perf_flush != '1)) perf_flush <= perf_flush + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: streaming, backpressure, redirects, halt and async reset.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        busy;
   logic        done;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
   logic [15:0] perf_flush;
`endif

   logic [31:0] imem [32];
   int          n_checks = 0;
   int          n_errors = 0;
   int          hs_cnt;

   fetch_controller_if fbus ();

   fetch_controller #(.MEM_DEPTH(30), .BOOT_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_bus      (fbus),
      .busy           (busy),
      .done           (done)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
      .perf_flush     (perf_flush)
`endif
   );

   always #5 clk = ~clk;

   // mem_addr is the memory's address register, so read data is valid in the cycle after issue.
   assign fbus.mem_instr = (fbus.mem_addr < 32'd32) ? imem[fbus.mem_addr[4:0]] : 32'hDEAD_BEEF;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) hs_cnt <= 0;
      else if (fbus.out_valid && fbus.out_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      redirect_valid = 1'b0;
      fbus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Pulses start at the current negedge; returns at the following negedge (N1).
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) imem[i] = 32'hC0DE_0000 + 32'(i);
      fbus.out_ready = 1'b0;

      // reset state and redirect ignored while idle
      do_reset();
      chk("rst_valid", 32'(fbus.out_valid), 32'd0);
      chk("rst_instr", fbus.out_instr, 32'd0);
      chk("rst_pc", fbus.out_pc, 32'd0);
      chk("rst_addr", fbus.mem_addr, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("idle_redir_busy", 32'(busy), 32'd0);

      // full stream of 30 words with out_ready held high; a second start mid-run is ignored
      do_reset();
      fbus.out_ready = 1'b1;
      pulse_start();
      chk("s1_busy", 32'(busy), 32'd1);
      chk("s1_valid_n1", 32'(fbus.out_valid), 32'd0);
      @(negedge clk);
      chk("s1_valid_n2", 32'(fbus.out_valid), 32'd0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("s1_valid", 32'(fbus.out_valid), 32'd1);
         chk("s1_pc", fbus.out_pc, 32'(4 * i));
         chk("s1_instr", fbus.out_instr, 32'hC0DE_0000 + 32'(i));
         chk("s1_done_early", 32'(done), 32'd0);
         start = (i == 10);
      end
      start = 1'b0;
      @(negedge clk);
      chk("s1_done", 32'(done), 32'd1);
      chk("s1_valid_end", 32'(fbus.out_valid), 32'd0);
      chk("s1_busy_halt", 32'(busy), 32'd1);
      chk("s1_last_addr", fbus.mem_addr, 32'd29);
      repeat (3) @(negedge clk);
      chk("s1_handshakes", 32'(hs_cnt), 32'd30);
`ifdef FETCH_PERF_CNT_EN
      chk("s1_perf_fetched", perf_fetched, 32'd30);
      chk("s1_perf_flush", 32'(perf_flush), 32'd0);
`endif

      // backpressure: hold out_ready low for 5 cycles after the first valid
      do_reset();
      pulse_start();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(fbus.out_valid), 32'd1);
         chk("bp_pc_hold", fbus.out_pc, 32'd0);
         chk("bp_instr_hold", fbus.out_instr, 32'hC0DE_0000);
         @(negedge clk);
      end
      chk("bp_issue_stop", fbus.mem_addr, 32'd1);
      fbus.out_ready = 1'b1;
      chk("bp_rel_pc0", fbus.out_pc, 32'd0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("bp_rel_valid", 32'(fbus.out_valid), 32'd1);
         chk("bp_rel_pc", fbus.out_pc, 32'(4 * i));
         chk("bp_rel_instr", fbus.out_instr, 32'hC0DE_0000 + 32'(i));
      end

      // redirect to 0x20 (low bits set) while word 3 is in flight
      do_reset();
      fbus.out_ready = 1'b1;
      pulse_start();
      repeat (4) @(negedge clk);
      chk("rd_pc_before", fbus.out_pc, 32'd8);
      chk("rd_addr_inflight", fbus.mem_addr, 32'd3);
      redirect_valid = 1'b1;
      redirect_pc = 32'h23;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rd_flush_valid", 32'(fbus.out_valid), 32'd0);
      @(negedge clk);
      chk("rd_gap_valid", 32'(fbus.out_valid), 32'd0);
      chk("rd_new_addr", fbus.mem_addr, 32'd8);
      @(negedge clk);
      chk("rd_new_valid", 32'(fbus.out_valid), 32'd1);
      chk("rd_new_pc", fbus.out_pc, 32'h20);
      chk("rd_new_instr", fbus.out_instr, 32'hC0DE_0008);
      @(negedge clk);
      chk("rd_next_pc", fbus.out_pc, 32'h24);
`ifdef FETCH_PERF_CNT_EN
      chk("rd_perf_flush", 32'(perf_flush), 32'd1);
`endif
      @(negedge clk);

      // redirect beyond the memory: halt without issuing
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rh_valid", 32'(fbus.out_valid), 32'd0);
      chk("rh_done", 32'(done), 32'd1);
      repeat (2) @(negedge clk);
      chk("rh_no_issue", fbus.mem_addr, 32'd11);
      chk("rh_busy", 32'(busy), 32'd1);
      chk("rh_done_hold", 32'(done), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("rh_perf_flush", 32'(perf_flush), 32'd2);
`endif

      // async reset between edges mid-stream, then restart
      do_reset();
      fbus.out_ready = 1'b1;
      pulse_start();
      repeat (5) @(negedge clk);
      chk("ar_pre_valid", 32'(fbus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(fbus.out_valid), 32'd0);
      chk("ar_instr", fbus.out_instr, 32'd0);
      chk("ar_pc", fbus.out_pc, 32'd0);
      chk("ar_addr", fbus.mem_addr, 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      repeat (2) @(negedge clk);
      chk("ar_restart_valid", 32'(fbus.out_valid), 32'd1);
      chk("ar_restart_pc", fbus.out_pc, 32'd0);
      @(negedge clk);
      chk("ar_restart_pc1", fbus.out_pc, 32'd4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the synchronous, word-indexed instruction memory.
- Owns the PC and issues one read per cycle. The memory returns data one clock after the address is presented.
- Buffers returned instructions in a 2-entry skid FIFO and presents them to decode over a valid/ready handshake.
- Handles start, branch redirect with flush, and end-of-program halt when the PC walks past MEM_DEPTH.

Parameters:
- MEM_DEPTH, 30: number of 32-bit words in instruction memory. The last valid word index is MEM_DEPTH-1.
- BOOT_PC, 32'h0: byte PC loaded at start.
- BUF_DEPTH, 2: skid FIFO entries. Fixed at 2; other values are not supported.

Ports:
- clk  in  1  rising-edge clock, shared with instruction memory
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins fetching from BOOT_PC
- redirect_valid  in  1  branch/jump taken; flushes the pipeline
- redirect_pc  in  32  new byte PC; bits [1:0] are ignored
- mem_addr  out  32  word index to instruction memory (pc>>2)
- mem_instr  in  32  memory read data, valid one cycle after mem_addr
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_instr  out  32  instruction word
- out_pc  out  32  byte PC of out_instr
- busy  out  1  state != IDLE
- done  out  1  HALT reached, FIFO empty, nothing in flight

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, pc=BOOT_PC, mem_addr=0, inflight=0, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, busy=0, done=0.
- States:
  - IDLE: start moves to FETCH with pc=BOOT_PC; redirect is ignored.
  - FETCH: issues reads.
  - HALT: issues nothing; remaining FIFO entries still drain.
- Issue rule in FETCH: issue when (count + inflight - deq) < 2, where deq = out_valid & out_ready.
  - On issue: mem_addr <= pc>>2; pc <= pc+4; inflight <= 1 with issue_pc tag.
  - When not issuing: inflight <= 0 and mem_addr holds its value.
- Response: a cycle with inflight=1 and no kill pushes {mem_instr, issue_pc} into the FIFO. Push and pop may occur in the same cycle.
- Latency: out_valid rises 2 cycles after start, with out_pc=BOOT_PC. Throughput is 1 instruction/cycle while out_ready=1.
- Handshake: while out_valid=1 and out_ready=0, out_instr and out_pc stay stable. out_valid never drops without a handshake, except on redirect.
- End of program: when the next issue would use word index >= MEM_DEPTH, move to HALT instead of issuing. done=1 once count=0 and inflight=0.
- Redirect (highest priority, FETCH or HALT), in the same cycle:
  - flush the FIFO (count=0, out_valid=0 next cycle);
  - mark the in-flight response killed;
  - pc <= {redirect_pc[31:2], 2'b00}.
  - If redirect_pc>>2 < MEM_DEPTH, go to FETCH and issue next cycle. Otherwise go to HALT.
  - A handshake in the redirect cycle still counts as accepted.
- start while busy is ignored.
- Reset mid-operation returns to IDLE immediately. All in-flight data is lost.
- PC arithmetic is 32-bit modulo.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_fetched [31:0]: increments per issue.
  - perf_stall [31:0]: increments per FETCH cycle with no issue.
  - perf_flush [15:0]: increments per accepted redirect.
- All counters clear on rst_n, saturate, and never wrap.
- When undefined, these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {IDLE, FETCH, HALT};
  - constants INSTR_W=32, PC_STEP=4;
  - a typedef fetch_entry_t {instr[31:0], pc[31:0]}.
- One sub-module, fetch_skid_fifo: 2-entry FIFO with push, pop, flush, count, head. It is reused for the decode-side buffer.

Test Plan:
- Reset, start, out_ready=1 held, memory preloaded with 30 words: out_pc sequence 0,4,…,116 with one word per cycle. HALT follows, then done=1 two cycles after the last issue. Exactly 30 handshakes.
- Backpressure: out_ready=0 for 5 cycles after the first valid. count=2, issue stops, out_pc=0 held stable. Release gives in-order 0,4,8 with no loss or duplication.
- Redirect to 32'h20 while an issue to word 3 is in flight. The killed word is never presented. The next out_valid carries out_pc=32'h20, two cycles later.
- Redirect to 32'h200 (word 128 ≥ 30): state goes to HALT with no issues. done=1 once the FIFO is empty.
- rst_n=0 mid-stream (async, between edges): all outputs return to their reset values immediately. start restarts at BOOT_PC.
- With FETCH_PERF_CNT_EN defined: scenario 1 gives perf_fetched=30 and perf_flush=0. The redirect scenario gives perf_flush=1.
